// File: rtl/serial_subtractor.sv
// serial_subtractor
//
// Bit-serial two's-complement subtractor. Computes A - B - Bin one bit per
// clock, LSB first, through a single full-subtractor cell and a registered
// borrow. Used as the low-area subtract/compare path next to the ALU's
// combinational ripple adder.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, sampled only while not busy (IDLE or FIN)
//   a, b   - minuend / subtrahend, captured when start is accepted
//   bin    - borrow-in, captured when start is accepted
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when diff/bout/flags become valid
//   diff   - A - B - Bin mod 2^WIDTH, held until the next result lands
//   bout   - final borrow-out (1 = unsigned A < B + Bin)
//   zero   - diff == 0                 (only with SERIAL_SUB_FLAGS_EN)
//   neg    - diff[WIDTH-1]             (only with SERIAL_SUB_FLAGS_EN)
//   ovf    - signed overflow of A - B  (only with SERIAL_SUB_FLAGS_EN)
//
// Build option: define SERIAL_SUB_FLAGS_EN to get registered zero/neg/ovf
// flags. Without it those outputs are tied to 0 and have no registers.

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Only WIDTH-1 partial bits need storing: the last bit goes straight
    // into diff on the finishing edge.
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_a, bit_b, bit_d, borrow_nx;
    logic [WIDTH-1:0] result_full;
    logic             finish;

    // Next-state and datapath logic. Start is only honoured in IDLE and FIN,
    // so a request arriving mid-operation is simply dropped. Accepting start
    // in FIN gives back-to-back operation with no idle cycle.
    always_comb begin
        state_d     = state_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        borrow_d    = borrow_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        finish      = 1'b0;

        bit_a       = ra_q[cnt_q];
        bit_b       = rb_q[cnt_q];
        bit_d       = bit_a ^ bit_b ^ borrow_q;
        borrow_nx   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
        result_full = {bit_d, res_q};

        case (state_q)
            IDLE, FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    ra_d     = a;
                    rb_d     = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                res_d    = result_full[WIDTH-1:1];
                borrow_d = borrow_nx;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    finish  = 1'b1;
                    diff_d  = result_full;
                    bout_d  = borrow_nx;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any operation in flight
    // and clears every output, so no done is produced for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

`ifdef SERIAL_SUB_FLAGS_EN
    logic zero_q, zero_d;
    logic neg_q, neg_d;
    logic ovf_q, ovf_d;

    // Flags are computed from the completed result on the same edge that
    // diff is loaded. Overflow looks only at the operand signs and the
    // result sign; the borrow-in does not take part.
    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        ovf_d  = ovf_q;
        if (finish) begin
            zero_d = (result_full == '0);
            neg_d  = result_full[WIDTH-1];
            ovf_d  = (ra_q[WIDTH-1] ^ rb_q[WIDTH-1]) &
                     (ra_q[WIDTH-1] ^ result_full[WIDTH-1]);
        end
    end

    // Flag registers share the datapath's asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
`else
    assign zero = 1'b0;
    assign neg  = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor (WIDTH=8). Expected results come
// from plain integer subtraction of the operands; flag expectations follow
// whether SERIAL_SUB_FLAGS_EN is defined for the build.

module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             neg;
    logic             ovf;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero),
        .neg   (neg),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: packs {diff, bout, zero, neg, ovf} from integer arithmetic.
    function automatic logic [11:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic mbin);
        int         raw;
        logic [7:0] md;
        logic       mbo, mz, mn, mo;
        raw = int'(ma) - int'(mb) - int'(mbin);
        md  = raw[7:0];
        mbo = (raw < 0);
`ifdef SERIAL_SUB_FLAGS_EN
        mz  = (md == 8'h00);
        mn  = md[7];
        mo  = (ma[7] != mb[7]) && (ma[7] != md[7]);
`else
        mz  = 1'b0;
        mn  = 1'b0;
        mo  = 1'b0;
`endif
        return {md, mbo, mz, mn, mo};
    endfunction

    // Pulse start for one clock with the given operands; returns at the
    // falling edge just after the accepting rising edge.
    task automatic launch(input logic [7:0] ta, input logic [7:0] tb_v, input logic tbin);
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        bin   = tbin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count falling edges until done is seen, bounded so a stuck DUT
    // cannot hang the run.
    task automatic wait_done(output int lat, output bit timed_out);
        lat       = 0;
        timed_out = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat       = k;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, diff, bout, zero, neg, ovf} !== 14'h0) begin
            bad++;
            $display("[TB] FAIL reset_state got=%h exp=0", {busy, done, diff, bout, zero, neg, ovf});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [7:0] va[5] = '{8'h05, 8'h03, 8'h80, 8'h00, 8'h10};
        logic [7:0] vb[5] = '{8'h03, 8'h05, 8'h01, 8'h00, 8'h10};
        logic       vc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [11:0] exp_v;
        int lat;
        bit to;
        for (int i = 0; i < 5; i++) begin
            exp_v = model(va[i], vb[i], vc[i]);
            launch(va[i], vb[i], vc[i]);
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL directed_busy[%0d] got=%b exp=1", i, busy);
            end
            wait_done(lat, to);
            total++;
            if (to || lat != WIDTH) begin
                bad++;
                $display("[TB] FAIL directed_latency[%0d] got=%0d exp=%0d timeout=%0d", i, lat, WIDTH, to);
            end
            total++;
            if ({diff, bout, zero, neg, ovf} !== exp_v || busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL directed_result[%0d] got=%h busy=%b exp=%h", i,
                         {diff, bout, zero, neg, ovf}, busy, exp_v);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || {diff, bout, zero, neg, ovf} !== exp_v) begin
                bad++;
                $display("[TB] FAIL directed_pulse[%0d] done=%b got=%h exp=%h", i, done,
                         {diff, bout, zero, neg, ovf}, exp_v);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  ra, rb;
        logic        rc;
        logic [11:0] exp_v;
        int lat;
        bit to;
        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp_v = model(ra, rb, rc);
            launch(ra, rb, rc);
            wait_done(lat, to);
            total++;
            if (to || lat != WIDTH || {diff, bout, zero, neg, ovf} !== exp_v) begin
                bad++;
                $display("[TB] FAIL random[%0d] a=%h b=%h bin=%b got=%h lat=%0d exp=%h", i, ra, rb, rc,
                         {diff, bout, zero, neg, ovf}, lat, exp_v);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [11:0] prev_v, exp_v;
        int lat;
        bit to;
        prev_v = {diff, bout, zero, neg, ovf};
        exp_v  = model(8'h5A, 8'h3C, 1'b1);
        launch(8'h5A, 8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        a     = 8'h11;
        b     = 8'hEE;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({diff, bout, zero, neg, ovf} !== prev_v || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midrun_hold got=%h busy=%b exp=%h", {diff, bout, zero, neg, ovf}, busy, prev_v);
        end
        wait_done(lat, to);
        total++;
        if (to || lat != WIDTH - 3 || {diff, bout, zero, neg, ovf} !== exp_v) begin
            bad++;
            $display("[TB] FAIL ignore_start got=%h lat=%0d exp=%h lat_exp=%0d", {diff, bout, zero, neg, ovf},
                     lat, exp_v, WIDTH - 3);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ignore_no_second busy=%b done=%b exp=0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp1, exp2;
        int lat;
        bit to;
        exp1 = model(8'h20, 8'h7F, 1'b0);
        exp2 = model(8'hC3, 8'h42, 1'b1);
        @(negedge clk);
        a     = 8'h20;
        b     = 8'h7F;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        wait_done(lat, to);
        total++;
        if (to || lat != WIDTH || {diff, bout, zero, neg, ovf} !== exp1) begin
            bad++;
            $display("[TB] FAIL b2b_first got=%h lat=%0d exp=%h", {diff, bout, zero, neg, ovf}, lat, exp1);
        end
        a   = 8'hC3;
        b   = 8'h42;
        bin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_no_gap busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        wait_done(lat, to);
        total++;
        if (to || lat != WIDTH || {diff, bout, zero, neg, ovf} !== exp2) begin
            bad++;
            $display("[TB] FAIL b2b_second got=%h lat=%0d exp=%h", {diff, bout, zero, neg, ovf}, lat, exp2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [11:0] exp_v;
        int lat;
        bit to;
        bit saw_done;
        launch(8'hFF, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({busy, done, diff, bout, zero, neg, ovf} !== 14'h0) begin
                bad++;
                $display("[TB] FAIL midrun_reset[%0d] got=%h exp=0", k, {busy, done, diff, bout, zero, neg, ovf});
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        total++;
        if (saw_done || {busy, diff, bout, zero, neg, ovf} !== 13'h0) begin
            bad++;
            $display("[TB] FAIL reset_abort saw_done=%b got=%h exp=0", saw_done, {busy, diff, bout, zero, neg, ovf});
        end
        exp_v = model(8'h44, 8'h45, 1'b0);
        launch(8'h44, 8'h45, 1'b0);
        wait_done(lat, to);
        total++;
        if (to || lat != WIDTH || {diff, bout, zero, neg, ovf} !== exp_v) begin
            bad++;
            $display("[TB] FAIL after_reset got=%h lat=%0d exp=%h", {diff, bout, zero, neg, ovf}, lat, exp_v);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
